brg_prog: RTL and testbench

Programmable UART baud rate generator. Divides fclk by a runtime-loadable divisor to produce a one-cycle oversample tick, then divides that by a parametrised oversample ratio to produce a bit tick and a mid-bit sample strobe. Divisor changes are glitch-free and take effect only at a tick boundary. Feeds the UART TX and RX blocks; all outputs are single-fclk-cycle enables, not derived clocks.

---
 rtl/brg_pkg.sv | 27 ++
 rtl/brg_prog_if.sv | 34 +++
 rtl/brg_prescaler.sv | 123 ++++++++++++
 rtl/brg_prog.sv | 62 ++++++
 tb/tb_brg_prog.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/brg_pkg.sv
// brg_pkg: shared parameters and divisor helpers for the baud generator.
// Optional fractional divisor is enabled with `define BRG_FRAC_EN.
package brg_pkg;

  localparam int DIV_W    = 16;
  localparam int OVS_LOG2 = 3;
  localparam int OVS      = 2 ** OVS_LOG2;
  localparam int FRAC_W   = 4;
  localparam int DEF_DIV  = 53;

  // Divisor register value for a given clock, baud and oversample ratio
  function automatic int calc_div(
    input longint fclk_hz,
    input longint baud,
    input int     ovs
  );
    longint den;
    den = baud * longint'(ovs);
    return int'((fclk_hz + den / 2) / den) - 1;
  endfunction

  localparam int DIV_9600_50M   = calc_div(50_000_000, 9600, OVS);
  localparam int DIV_19200_50M  = calc_div(50_000_000, 19200, OVS);
  localparam int DIV_38400_50M  = calc_div(50_000_000, 38400, OVS);
  localparam int DIV_115200_50M = calc_div(50_000_000, 115200, OVS);

endpackage

// File: rtl/brg_prog_if.sv
// brg_prog_if: control inputs and tick outputs of the baud generator.
// frac_in exists only with `define BRG_FRAC_EN.
interface brg_prog_if;
  import brg_pkg::*;

  logic             en;
  logic             div_wr;
  logic [DIV_W-1:0] div_in;
`ifdef BRG_FRAC_EN
  logic [FRAC_W-1:0] frac_in;
`endif
  logic             bclkx8;
  logic             bclk;
  logic             bclk_mid;
  logic             div_pend;
  logic [DIV_W-1:0] div_act;

  modport master (
    output en, div_wr, div_in,
`ifdef BRG_FRAC_EN
    output frac_in,
`endif
    input  bclkx8, bclk, bclk_mid, div_pend, div_act
  );

  modport slave (
    input  en, div_wr, div_in,
`ifdef BRG_FRAC_EN
    input  frac_in,
`endif
    output bclkx8, bclk, bclk_mid, div_pend, div_act
  );

endinterface

// File: rtl/brg_prescaler.sv
// brg_prescaler: reloadable down-counter producing the oversample tick.
// Holds pending/active divisor; fractional accumulator with `define BRG_FRAC_EN.
import brg_pkg::*;

module brg_prescaler (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_in,
`ifdef BRG_FRAC_EN
  input  logic [FRAC_W-1:0] frac_in,
`endif
  output logic              fire,
  output logic              bclkx8,
  output logic              div_pend,
  output logic [DIV_W-1:0]  div_act
);

`ifdef BRG_FRAC_EN
  localparam int CW = DIV_W + 1;
`else
  localparam int CW = DIV_W;
`endif

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             x8_q, x8_d;
  logic [DIV_W-1:0] div_nxt;
  logic             apply;
  logic             carry;
`ifdef BRG_FRAC_EN
  logic [FRAC_W-1:0] fact_q, fact_d;
  logic [FRAC_W-1:0] fpval_q, fpval_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
`endif

  // Next-state: divisor hand-over at tick boundaries, count and reload
  always_comb begin
    fire    = en && (cnt_q == '0);
    apply   = en ? (cnt_q == '0) : pend_q;
    div_nxt = act_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    carry   = 1'b0;
`ifdef BRG_FRAC_EN
    fact_d  = fact_q;
    fpval_d = fpval_q;
    acc_d   = acc_q;
`endif
    if (div_wr) begin
      pval_d = div_in;
      pend_d = 1'b1;
`ifdef BRG_FRAC_EN
      fpval_d = frac_in;
`endif
    end
    if (apply) begin
      pend_d = 1'b0;
      if (div_wr) begin
        div_nxt = div_in;
`ifdef BRG_FRAC_EN
        fact_d  = frac_in;
`endif
      end else if (pend_q) begin
        div_nxt = pval_q;
`ifdef BRG_FRAC_EN
        fact_d  = fpval_q;
`endif
      end
    end
    act_d = div_nxt;
`ifdef BRG_FRAC_EN
    if (!en) begin
      acc_d = '0;
    end else if (fire) begin
      {carry, acc_d} = {1'b0, acc_q} + {1'b0, fact_d};
    end
`endif
    x8_d = fire;
    if (!en) begin
      cnt_d = CW'(div_nxt);
    end else if (fire) begin
      cnt_d = CW'(div_nxt) + CW'(carry);
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= CW'(DEF_DIV);
      act_q  <= DIV_W'(DEF_DIV);
      pval_q <= '0;
      pend_q <= 1'b0;
      x8_q   <= 1'b0;
`ifdef BRG_FRAC_EN
      fact_q  <= '0;
      fpval_q <= '0;
      acc_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pval_q <= pval_d;
      pend_q <= pend_d;
      x8_q   <= x8_d;
`ifdef BRG_FRAC_EN
      fact_q  <= fact_d;
      fpval_q <= fpval_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign bclkx8   = x8_q;
  assign div_pend = pend_q;
  assign div_act  = act_q;

endmodule

// File: rtl/brg_prog.sv
// brg_prog: programmable UART baud generator (oversample, bit, mid-bit ticks).
// Fractional divisor support is built with `define BRG_FRAC_EN.
import brg_pkg::*;

module brg_prog (
  input logic       fclk,
  input logic       rst_n,
  brg_prog_if.slave bus
);

  localparam logic [OVS_LOG2-1:0] OVS_LAST = OVS_LOG2'(OVS - 1);
  localparam logic [OVS_LOG2-1:0] OVS_MID  = OVS_LOG2'(OVS / 2 - 1);

  logic                fire;
  logic [OVS_LOG2-1:0] ovs_cnt_q, ovs_cnt_d;
  logic                bclk_q, bclk_d;
  logic                mid_q, mid_d;

  brg_prescaler u_pre (
    .clk      (fclk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .div_wr   (bus.div_wr),
    .div_in   (bus.div_in),
`ifdef BRG_FRAC_EN
    .frac_in  (bus.frac_in),
`endif
    .fire     (fire),
    .bclkx8   (bus.bclkx8),
    .div_pend (bus.div_pend),
    .div_act  (bus.div_act)
  );

  // Sample counter and bit / mid-bit strobes aligned with the oversample tick
  always_comb begin
    ovs_cnt_d = ovs_cnt_q;
    if (!bus.en) begin
      ovs_cnt_d = '0;
    end else if (fire) begin
      ovs_cnt_d = ovs_cnt_q + 1'b1;
    end
    bclk_d = fire && (ovs_cnt_q == OVS_LAST);
    mid_d  = fire && (ovs_cnt_q == OVS_MID);
  end

  // Registered strobes
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      ovs_cnt_q <= '0;
      bclk_q    <= 1'b0;
      mid_q     <= 1'b0;
    end else begin
      ovs_cnt_q <= ovs_cnt_d;
      bclk_q    <= bclk_d;
      mid_q     <= mid_d;
    end
  end

  assign bus.bclk     = bclk_q;
  assign bus.bclk_mid = mid_q;

endmodule

// File: tb/tb_brg_prog.sv
// tb_brg_prog: directed + random checks of brg_prog against a period-level model.
// Fractional expectations follow `define BRG_FRAC_EN.
module tb_brg_prog;
  import brg_pkg::*;

  logic fclk = 1'b0;
  logic rst_n = 1'b0;
  brg_prog_if bus_if ();

  brg_prog dut (
    .fclk  (fclk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 fclk = ~fclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // period-level reference model
  int m_act, m_pval, m_per, m_el, m_nt, m_acc, m_fact, m_fpval;
  bit m_pend;
  bit e_x8, e_b, e_m;

  // interval checks
  bit gap_on = 0;
  int gap_len = 0;
  int lx = -1, lb = -1, lm = -1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = DEF_DIV; m_pend = 0; m_pval = 0;
    m_per = DEF_DIV + 1; m_el = 0; m_nt = 0;
    m_acc = 0; m_fact = 0; m_fpval = 0;
    e_x8 = 0; e_b = 0; e_m = 0;
  endtask

  task automatic model_edge();
    bit wr;
    int din, fin, c;
    wr  = bus_if.div_wr;
    din = int'(bus_if.div_in);
`ifdef BRG_FRAC_EN
    fin = int'(bus_if.frac_in);
`else
    fin = 0;
`endif
    e_x8 = 0; e_b = 0; e_m = 0;
    if (!bus_if.en) begin
      m_el = 0; m_nt = 0; m_acc = 0;
      if (m_pend) begin
        if (wr) begin m_act = din; m_fact = fin; end
        else begin m_act = m_pval; m_fact = m_fpval; end
        m_pend = 0;
      end else if (wr) begin
        m_pend = 1; m_pval = din; m_fpval = fin;
      end
      m_per = m_act + 1;
    end else begin
      m_el++;
      if (m_el == m_per) begin
        e_x8 = 1;
        e_b = (m_nt % OVS) == OVS - 1;
        e_m = (m_nt % OVS) == OVS / 2 - 1;
        m_nt++;
        if (wr) begin m_act = din; m_fact = fin; end
        else if (m_pend) begin m_act = m_pval; m_fact = m_fpval; end
        m_pend = 0;
        m_el = 0;
        c = 0;
`ifdef BRG_FRAC_EN
        m_acc += m_fact;
        if (m_acc >= (1 << FRAC_W)) begin
          c = 1;
          m_acc -= (1 << FRAC_W);
        end
`endif
        m_per = m_act + 1 + c;
      end else if (wr) begin
        m_pend = 1; m_pval = din; m_fpval = fin;
      end
    end
  endtask

  task automatic step();
    @(posedge fclk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    cyc++;
    chk("bclkx8", 32'(bus_if.bclkx8), 32'(e_x8));
    chk("bclk", 32'(bus_if.bclk), 32'(e_b));
    chk("bclk_mid", 32'(bus_if.bclk_mid), 32'(e_m));
    chk("div_pend", 32'(bus_if.div_pend), 32'(m_pend));
    chk("div_act", 32'(bus_if.div_act), 32'(m_act));
    if (gap_on) begin
      if (bus_if.bclkx8) begin
        if (lx >= 0) chk("x8_gap", 32'(cyc - lx), 32'(gap_len));
        lx = cyc;
      end
      if (bus_if.bclk_mid) lm = cyc;
      if (bus_if.bclk) begin
        if (lb >= 0) chk("bclk_gap", 32'(cyc - lb), 32'(gap_len * OVS));
        if (lm >= 0) chk("mid_lead", 32'(cyc - lm), 32'(gap_len * OVS / 2));
        lb = cyc;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_div(input int d, input int f);
    bus_if.div_wr = 1'b1;
    bus_if.div_in = DIV_W'(d);
`ifdef BRG_FRAC_EN
    bus_if.frac_in = FRAC_W'(f);
`else
    if (f != 0) $display("note: frac ignored in this build");
`endif
    step();
    bus_if.div_wr = 1'b0;
  endtask

  task automatic gap_start(input int g);
    gap_on = 1; gap_len = g; lx = -1; lb = -1; lm = -1;
  endtask

  initial begin
    int ticks, last, total, longp, g, guard;
    bit seen;
    bus_if.en = 1'b0;
    bus_if.div_wr = 1'b0;
    bus_if.div_in = '0;
`ifdef BRG_FRAC_EN
    bus_if.frac_in = '0;
`endif
    model_reset();

    // reset held 3 cycles, then idle with en=0
    steps(3);
    rst_n = 1'b1;
    steps(100);

    // default rate
    bus_if.en = 1'b1;
    gap_start(DEF_DIV + 1);
    steps(1000);
    gap_on = 0;

    // divisor 0: tick every cycle
    bus_if.en = 1'b0;
    wr_div(0, 0);
    steps(2);
    bus_if.en = 1'b1;
    gap_start(1);
    steps(40);
    gap_on = 0;

    // glitch-free change with overwrite of the pending value
    bus_if.en = 1'b0;
    wr_div(53, 0);
    steps(2);
    bus_if.en = 1'b1;
    steps(20);
    wr_div(9, 0);
    steps(5);
    wr_div(4, 0);
    chk("pend_held", 32'(bus_if.div_pend), 32'd1);
    steps(300);

    // mid-operation reset
    bus_if.en = 1'b0;
    wr_div(53, 0);
    steps(2);
    bus_if.en = 1'b1;
    guard = 0;
    seen = 0;
    while (!seen && guard < 200) begin
      step();
      seen = bus_if.bclkx8;
      guard++;
    end
    chk("x8_before_reset", 32'(seen), 32'd1);
    steps(20);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_x8", 32'(bus_if.bclkx8), 32'd0);
    chk("rst_bclk", 32'(bus_if.bclk), 32'd0);
    chk("rst_mid", 32'(bus_if.bclk_mid), 32'd0);
    chk("rst_act", 32'(bus_if.div_act), 32'(DEF_DIV));
    steps(2);
    rst_n = 1'b1;
    gap_start(DEF_DIV + 1);
    lx = cyc;
    steps(120);
    gap_on = 0;

    // fractional divisor: 16 periods after the first
    bus_if.en = 1'b0;
    wr_div(53, 4);
    steps(2);
    bus_if.en = 1'b1;
    ticks = 0; last = 0; total = 0; longp = 0; guard = 0;
    while (ticks < 17 && guard < 3000) begin
      step();
      guard++;
      if (bus_if.bclkx8) begin
        ticks++;
        if (ticks >= 2) begin
          g = cyc - last;
          total += g;
          if (g == 55) longp++;
        end
        last = cyc;
      end
    end
    chk("frac_done", 32'(ticks), 32'd17);
`ifdef BRG_FRAC_EN
    chk("frac_total", 32'(total), 32'd868);
    chk("frac_long", 32'(longp), 32'd4);
`else
    chk("frac_total", 32'(total), 32'd864);
    chk("frac_long", 32'(longp), 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) bus_if.en = ~bus_if.en;
      bus_if.div_wr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0)
        bus_if.div_in = DIV_W'($urandom_range(0, 60));
      else
        bus_if.div_in = DIV_W'($urandom_range(0, 10));
`ifdef BRG_FRAC_EN
      bus_if.frac_in = FRAC_W'($urandom_range(0, 15));
`endif
      step();
    end
    bus_if.div_wr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
